// File: rtl/timer_pkg.sv
// Shared types, 7-segment constants and per-digit count limits for the BCD timer.
// Build with TIMER_SEXAGESIMAL_EN defined to make digits 3 and 5 count mod 6 (MM:SS.cc).
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef enum logic [1:0] {M_UP = 2'b00, M_DOWN = 2'b01, M_HOLD = 2'b10, M_UP2 = 2'b11} mode_t;

  // Active-low segments, a..g in [6:0]
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [9:0][6:0] SEG_LUT =
    {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

`ifdef TIMER_SEXAGESIMAL_EN
  localparam bit SEXA = 1'b1;
`else
  localparam bit SEXA = 1'b0;
`endif

  function automatic logic [3:0] bcd_limit(input int idx);
    return (SEXA && (idx == 3 || idx == 5)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_LUT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/timer_core_param_seg_scan.sv
// Multiplexed 7-segment scanner: walks the digit index, decodes the selected digit,
// and registers AN/HEX so both change together one cycle after the index.
module seg_scan
  import timer_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int SDIV   = 100_000,
  parameter int DP_POS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            hex
);
  localparam int SW = (SDIV > 1) ? $clog2(SDIV) : 1;
  localparam int IW = $clog2(DIGITS);

  logic [SW-1:0] scan;
  logic [IW-1:0] idx;
  logic [3:0]    cur;

  assign cur = digits[4*idx +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
      idx  <= '0;
      an   <= '1;
      hex  <= 8'hFF;
    end else begin
      if (scan == SW'(SDIV - 1)) begin
        scan <= '0;
        idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        scan <= scan + SW'(1);
      end
      an  <= ~(DIGITS'(1) << idx);
      hex <= {(int'(idx) != DP_POS), seg7(cur)};
    end
  end

endmodule

// File: rtl/timer_core_param.sv
// N-digit BCD stopwatch / countdown timer with pause, hold and lap-freeze display.
// TIMER_SEXAGESIMAL_EN: digits 3 and 5 count mod 6; otherwise every digit is mod 10.
module timer_core_param
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 8,
  parameter int DP_POS  = 2
) (
  input  logic                clock_100MHZ,
  input  logic                reset,
  input  logic                start,
  input  logic                suspend,
  input  logic [1:0]          mode,
  input  logic [4*DIGITS-1:0] preset,
  input  logic                lap,
  output logic [DIGITS-1:0]   AN,
  output logic [7:0]          HEX,
  output logic [15:0]         LED,
  output logic                alarm
);
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int SDIV = CLK_HZ / SCAN_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

  state_t  state;
  mode_t   mode_l;
  logic [PW-1:0] presc;
  logic    tick, ovf, lap_q, inc_ovf;
  logic [DIGITS-1:0][3:0] cnt, shadow, pre_c, ld_val, inc_v, dec_v, disp;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    localparam logic [3:0] LIM = bcd_limit(g);
    assign pre_c[g] = (preset[4*g +: 4] > LIM) ? LIM : preset[4*g +: 4];
  end

  assign ld_val = (mode == 2'b01 || mode == 2'b10) ? pre_c : '0;
  assign tick   = (presc == PW'(DIV - 1));

  // Ripple carry/borrow; each digit wraps at its own limit.
  always_comb begin
    logic c, b;
    inc_v = cnt;
    dec_v = cnt;
    c = 1'b1;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (cnt[i] >= bcd_limit(i)) inc_v[i] = 4'd0;
        else begin inc_v[i] = cnt[i] + 4'd1; c = 1'b0; end
      end
      if (b) begin
        if (cnt[i] == 4'd0) dec_v[i] = bcd_limit(i);
        else begin dec_v[i] = cnt[i] - 4'd1; b = 1'b0; end
      end
    end
    inc_ovf = c;
  end

  always_ff @(posedge clock_100MHZ or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mode_l <= M_UP;
      cnt    <= '0;
      presc  <= '0;
      ovf    <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          presc  <= '0;
          mode_l <= mode_t'(mode);
          cnt    <= ld_val;
          if (start) begin
            state <= RUN;
            ovf   <= 1'b0;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (!start) begin
            state <= IDLE;
            presc <= '0;
            cnt   <= ld_val;
          end else if (suspend) begin
            state <= PAUSE;
          end else if (mode_l == M_DOWN && cnt == '0) begin
            state <= DONE;
            alarm <= 1'b1;
          end else if (tick) begin
            case (mode_l)
              M_DOWN: begin
                cnt <= dec_v;
                if (dec_v == '0) begin
                  state <= DONE;
                  alarm <= 1'b1;
                end
              end
              M_HOLD:  cnt <= cnt;
              default: begin
                cnt <= inc_v;
                if (inc_ovf) ovf <= 1'b1;
              end
            endcase
          end
        end
        PAUSE: begin
          if (!start) begin
            state <= IDLE;
            presc <= '0;
            cnt   <= ld_val;
          end else if (!suspend) begin
            state <= RUN;
          end
        end
        default: begin
          cnt <= '0;
          if (!start) begin
            state <= IDLE;
            alarm <= 1'b0;
            presc <= '0;
            cnt   <= ld_val;
          end
        end
      endcase
    end
  end

  // Lap snapshot: taken on the rising edge of lap; the counter keeps running.
  always_ff @(posedge clock_100MHZ or negedge reset) begin
    if (!reset) begin
      lap_q  <= 1'b0;
      shadow <= '0;
    end else begin
      lap_q <= lap;
      if (lap && !lap_q) shadow <= cnt;
    end
  end

  assign disp = (lap && lap_q) ? shadow : cnt;

  assign LED = {1'b0, mode_l, 8'b0, lap_q, ovf,
                (state == DONE), (state == PAUSE), (state == RUN)};

  seg_scan #(.DIGITS(DIGITS), .SDIV(SDIV), .DP_POS(DP_POS)) u_scan (
    .clk    (clock_100MHZ),
    .rst_n  (reset),
    .digits (disp),
    .an     (AN),
    .hex    (HEX)
  );

endmodule

// File: tb/tb_timer_core_param.sv
// Scoreboard bench for timer_core_param: an 8-digit instance for the main modes and
// display scan, and a 2-digit instance for overflow wrap and lap freeze.
module tb_timer_core_param;

  logic        clk = 1'b0;
  logic        reset, start, suspend, lap;
  logic [1:0]  mode;
  logic [31:0] preset;
  logic [7:0]  AN, HEX;
  logic [15:0] LED;
  logic        alarm;

  logic        start2, suspend2, lap2;
  logic [1:0]  mode2;
  logic [7:0]  preset2;
  logic [1:0]  AN2;
  logic [7:0]  HEX2;
  logic [15:0] LED2;
  logic        alarm2;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  timer_core_param #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250), .DIGITS(8), .DP_POS(2)) dut (
    .clock_100MHZ(clk), .reset(reset), .start(start), .suspend(suspend), .mode(mode),
    .preset(preset), .lap(lap), .AN(AN), .HEX(HEX), .LED(LED), .alarm(alarm));

  timer_core_param #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250), .DIGITS(2), .DP_POS(2)) dut2 (
    .clock_100MHZ(clk), .reset(reset), .start(start2), .suspend(suspend2), .mode(mode2),
    .preset(preset2), .lap(lap2), .AN(AN2), .HEX(HEX2), .LED(LED2), .alarm(alarm2));

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'h3F; 1: on = 7'h06; 2: on = 7'h5B; 3: on = 7'h4F; 4: on = 7'h66;
      5: on = 7'h6D; 6: on = 7'h7D; 7: on = 7'h07; 8: on = 7'h7F; 9: on = 7'h6F;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; suspend = 1'b0; lap = 1'b0; mode = 2'b00; preset = '0;
    start2 = 1'b0; suspend2 = 1'b0; lap2 = 1'b0; mode2 = 2'b00; preset2 = '0;
    sb.push_back(32'hFF); sb.push_back(32'hFF); sb.push_back(32'h0); sb.push_back(32'h0);
    cyc(5);
    exp_v = sb.pop_front(); checks++;
    if ({24'h0, AN} !== exp_v) begin errors++; $display("FAIL reset_an got %h want %h", AN, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({24'h0, HEX} !== exp_v) begin errors++; $display("FAIL reset_hex got %h want %h", HEX, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({16'h0, LED} !== exp_v) begin errors++; $display("FAIL reset_led got %h want %h", LED, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, alarm} !== exp_v) begin errors++; $display("FAIL reset_alarm got %h want %h", alarm, exp_v); end
    reset = 1'b1;
  endtask

  task automatic test_up;
    mode = 2'b00; start = 1'b1;
    sb.push_back(32'h1); sb.push_back(32'h1); sb.push_back(32'h5);
    cyc(1);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, LED[0]} !== exp_v) begin errors++; $display("FAIL up_led_run got %h want %h", LED[0], exp_v); end
    cyc(10);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL up_first_tick got %h want %h", dut.cnt, exp_v); end
    cyc(40);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL up_50 got %h want %h", dut.cnt, exp_v); end
  endtask

  task automatic test_pause;
    start = 1'b0; cyc(1);
    start = 1'b1; cyc(1);
    sb.push_back(32'h3); sb.push_back(32'h3); sb.push_back(32'h1);
    sb.push_back(32'h3); sb.push_back(32'h4);
    cyc(30);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL pause_pre got %h want %h", dut.cnt, exp_v); end
    cyc(4);
    suspend = 1'b1;
    cyc(100);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL pause_hold got %h want %h", dut.cnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, LED[1]} !== exp_v) begin errors++; $display("FAIL pause_led got %h want %h", LED[1], exp_v); end
    suspend = 1'b0;
    cyc(5);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL pause_resume5 got %h want %h", dut.cnt, exp_v); end
    cyc(1);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL pause_resume6 got %h want %h", dut.cnt, exp_v); end
  endtask

  task automatic test_countdown;
    start = 1'b0; mode = 2'b01; preset = 32'h3;
    sb.push_back(32'h3); sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h1);
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    cyc(1);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL down_load got %h want %h", dut.cnt, exp_v); end
    start = 1'b1; cyc(1);
    cyc(29);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, alarm} !== exp_v) begin errors++; $display("FAIL down_early_alarm got %h want %h", alarm, exp_v); end
    cyc(1);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, alarm} !== exp_v) begin errors++; $display("FAIL down_alarm got %h want %h", alarm, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, LED[2]} !== exp_v) begin errors++; $display("FAIL down_led_done got %h want %h", LED[2], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL down_zero got %h want %h", dut.cnt, exp_v); end
    start = 1'b0; cyc(1);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, alarm} !== exp_v) begin errors++; $display("FAIL down_alarm_clr got %h want %h", alarm, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, LED[2]} !== exp_v) begin errors++; $display("FAIL down_led_clr got %h want %h", LED[2], exp_v); end
  endtask

  task automatic test_clamp_hold;
    mode = 2'b01; preset = 32'h0070_70A5;
`ifdef TIMER_SEXAGESIMAL_EN
    sb.push_back(32'h0050_5095);
`else
    sb.push_back(32'h0070_7095);
`endif
    cyc(1);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL clamp got %h want %h", dut.cnt, exp_v); end
    mode = 2'b10; preset = 32'h0000_0042;
    sb.push_back(32'h42); sb.push_back(32'h2);
    cyc(1);
    start = 1'b1; cyc(1);
    mode = 2'b00;
    cyc(25);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL hold_count got %h want %h", dut.cnt, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({30'h0, LED[14:13]} !== exp_v) begin errors++; $display("FAIL hold_mode_led got %h want %h", LED[14:13], exp_v); end
    start = 1'b0; cyc(1);
  endtask

  task automatic test_zero_entry;
    mode = 2'b01; preset = '0;
    sb.push_back(32'h1); sb.push_back(32'h0); sb.push_back(32'h1);
    cyc(1);
    start = 1'b1; cyc(1);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, LED[0]} !== exp_v) begin errors++; $display("FAIL zero_run got %h want %h", LED[0], exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, alarm} !== exp_v) begin errors++; $display("FAIL zero_no_alarm_yet got %h want %h", alarm, exp_v); end
    cyc(1);
    exp_v = sb.pop_front(); checks++;
    if ({31'h0, alarm} !== exp_v) begin errors++; $display("FAIL zero_done got %h want %h", alarm, exp_v); end
    start = 1'b0; cyc(1);
  endtask

  task automatic test_borrow;
    mode = 2'b01;
`ifdef TIMER_SEXAGESIMAL_EN
    preset = 32'h0001_0000; sb.push_back(32'h0000_5999);
`else
    preset = 32'h0000_0100; sb.push_back(32'h0000_0099);
`endif
    cyc(1);
    start = 1'b1; cyc(1);
    cyc(10);
    exp_v = sb.pop_front(); checks++;
    if (dut.cnt !== exp_v) begin errors++; $display("FAIL borrow got %h want %h", dut.cnt, exp_v); end
    start = 1'b0; cyc(1);
  endtask

  task automatic test_scan;
    logic [7:0] prev;
    logic [31:0] val;
    bit found;
    int d;
    val = 32'h1234_5678;
    mode = 2'b10; preset = val; start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      d = c / 4;
      sb.push_back({24'h0, ~(8'h01 << d)});
      sb.push_back({24'h0, (d != 2), seg_ref(int'(val[4*d +: 4]))});
    end
    cyc(2);
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      prev = AN;
      cyc(1);
      if (AN == 8'hFE && prev != 8'hFE) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL scan_sync got %h want %h", AN, 8'hFE); end
    for (int c = 0; c < 32; c++) begin
      exp_v = sb.pop_front(); checks++;
      if ({24'h0, AN} !== exp_v) begin errors++; $display("FAIL scan_an c=%0d got %h want %h", c, AN, exp_v[7:0]); end
      exp_v = sb.pop_front(); checks++;
      if ({24'h0, HEX} !== exp_v) begin errors++; $display("FAIL scan_hex c=%0d got %h want %h", c, HEX, exp_v[7:0]); end
      cyc(1);
    end
  endtask

  task automatic test_overflow_lap;
    bit shown;
    mode2 = 2'b00; preset2 = '0; start2 = 1'b1;
    sb.push_back(32'h07); sb.push_back(32'h1); sb.push_back({25'h0, seg_ref(7)});
    sb.push_back(32'h09); sb.push_back(32'h99); sb.push_back(32'h0);
    sb.push_back(32'h00); sb.push_back(32'h1);
    cyc(1);
    shown = 1'b0;
    for (int el = 1; el <= 1000; el++) begin
      cyc(1);
      if (el == 70) begin
        exp_v = sb.pop_front(); checks++;
        if ({24'h0, dut2.cnt} !== exp_v) begin errors++; $display("FAIL ovf_at70 got %h want %h", dut2.cnt, exp_v); end
        lap2 = 1'b1;
      end
      if (el == 75) begin
        exp_v = sb.pop_front(); checks++;
        if ({31'h0, LED2[4]} !== exp_v) begin errors++; $display("FAIL lap_led got %h want %h", LED2[4], exp_v); end
      end
      if (el >= 80 && el < 88 && !shown && AN2 == 2'b10) begin
        shown = 1'b1;
        exp_v = sb.pop_front(); checks++;
        if ({25'h0, HEX2[6:0]} !== exp_v) begin errors++; $display("FAIL lap_display got %h want %h", HEX2[6:0], exp_v[6:0]); end
      end
      if (el == 88 && !shown) begin
        exp_v = sb.pop_front(); checks++; errors++;
        $display("FAIL lap_display got digit0 never selected want %h", exp_v[6:0]);
      end
      if (el == 90) begin
        exp_v = sb.pop_front(); checks++;
        if ({24'h0, dut2.cnt} !== exp_v) begin errors++; $display("FAIL lap_runs got %h want %h", dut2.cnt, exp_v); end
      end
      if (el == 95) lap2 = 1'b0;
      if (el == 999) begin
        exp_v = sb.pop_front(); checks++;
        if ({24'h0, dut2.cnt} !== exp_v) begin errors++; $display("FAIL ovf_999 got %h want %h", dut2.cnt, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if ({31'h0, LED2[3]} !== exp_v) begin errors++; $display("FAIL ovf_flag_early got %h want %h", LED2[3], exp_v); end
      end
      if (el == 1000) begin
        exp_v = sb.pop_front(); checks++;
        if ({24'h0, dut2.cnt} !== exp_v) begin errors++; $display("FAIL ovf_wrap got %h want %h", dut2.cnt, exp_v); end
        exp_v = sb.pop_front(); checks++;
        if ({31'h0, LED2[3]} !== exp_v) begin errors++; $display("FAIL ovf_flag got %h want %h", LED2[3], exp_v); end
      end
    end
    start2 = 1'b0; cyc(1);
  endtask

  initial begin
    test_reset;
    test_up;
    test_pause;
    test_countdown;
    test_clamp_hold;
    test_zero_entry;
    test_borrow;
    test_scan;
    test_overflow_lap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
